// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and receiver FSM encoding, common to the
// VGA timing generator and the sync receiver.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_TOTAL  = 525;

    localparam bit VGA_SYNC_ACTIVE_LOW = 1'b1;
    localparam int VGA_LOCK_FRAMES     = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one raw sync line, delays it once more and reports leading
// (to asserted) and trailing (to deasserted) edges in normalised polarity.
module sync_edge_detect
    import vga_timing_pkg::*;
#(
    parameter bit ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_raw,
    output logic lead,
    output logic trail
);

    logic sync_q;
    logic sync_d;
    logic act_q;
    logic act_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= ACTIVE_LOW;
            sync_d <= ACTIVE_LOW;
        end else begin
            sync_q <= sync_raw;
            sync_d <= sync_q;
        end
    end

    // Active-high view of both taps, whatever the line polarity.
    assign act_q = sync_q ^ ACTIVE_LOW;
    assign act_d = sync_d ^ ACTIVE_LOW;
    assign lead  = act_q & ~act_d;
    assign trail = ~act_q & act_d;

endmodule

// File: rtl/vga_sync_receiver.sv
// Locks to an HS/VS pair, rebuilds hcount/vcount/blank/frame_start and flags
// timing violations. Define SYNC_WIDTH_CHECK_EN to also check sync pulse widths.
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter bit SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW,
    parameter int LOCK_FRAMES     = VGA_LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        blank,
    output logic        frame_start,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [10:0] H_ALIGN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] V_ALIGN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] H_TRAIL  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_TRAIL  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [11:0] TO_LIMIT = 12'(2 * H_TOTAL - 1);
    localparam logic [3:0]  CLEAN_LAST = 4'(LOCK_FRAMES - 1);

`ifdef SYNC_WIDTH_CHECK_EN
    localparam bit WIDTH_CHECK = 1'b1;
`else
    localparam bit WIDTH_CHECK = 1'b0;
`endif

    rx_state_t   state;
    logic        hs_lead, hs_trail, vs_lead, vs_trail;
    logic [10:0] h_free, v_free, h_nxt, v_nxt;
    logic [11:0] to_cnt;
    logic [3:0]  clean_cnt;
    logic        dirty;
    logic        checking, line_err_c, frame_err_c, err_c, err_q;
    logic        timeout, promote, locked_nxt;

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_edge (
        .clk      (clk),
        .rst      (rst),
        .sync_raw (hs),
        .lead     (hs_lead),
        .trail    (hs_trail)
    );

    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_edge (
        .clk      (clk),
        .rst      (rst),
        .sync_raw (vs),
        .lead     (vs_lead),
        .trail    (vs_trail)
    );

    // Free-running successor, i.e. where the counters would land without any sync edge.
    always_comb begin
        h_free = (hcount == H_LAST) ? 11'd0 : hcount + 11'd1;
        v_free = vcount;
        if (hcount == H_LAST) begin
            v_free = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
        end
    end

    assign checking    = (state != SEARCH);
    assign line_err_c  = checking && ((hs_lead && h_free != H_ALIGN) ||
                                      (WIDTH_CHECK && hs_trail && h_free != H_TRAIL));
    assign frame_err_c = checking && ((vs_lead && v_free != V_ALIGN) ||
                                      (WIDTH_CHECK && vs_trail && v_free != V_TRAIL));
    assign err_c       = line_err_c | frame_err_c;
    assign err_q       = line_err | frame_err;
    assign timeout     = checking && !hs_lead && (to_cnt >= TO_LIMIT);
    assign promote     = (state == VERIFY) && vs_lead && !err_c && !dirty &&
                         (clean_cnt == CLEAN_LAST) && !timeout;
    assign locked_nxt  = ((state == LOCKED) && !err_q && !timeout) || promote;

    always_comb begin
        h_nxt = h_free;
        v_nxt = v_free;
        if (state == SEARCH) begin
            h_nxt = 11'd0;
            v_nxt = 11'd0;
            if (vs_lead) begin
                v_nxt = V_ALIGN;
                if (hs_lead) h_nxt = H_ALIGN;
            end
        end else if (timeout) begin
            h_nxt = 11'd0;
            v_nxt = 11'd0;
        end else begin
            if (hs_lead) h_nxt = H_ALIGN;
            if (vs_lead) v_nxt = V_ALIGN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEARCH;
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            to_cnt      <= 12'd0;
            clean_cnt   <= 4'd0;
            dirty       <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            line_err    <= line_err_c;
            frame_err   <= frame_err_c;
            locked      <= locked_nxt;
            blank       <= !locked_nxt || (h_nxt >= H_VIS) || (v_nxt >= V_VIS);
            frame_start <= locked_nxt && (h_nxt == 11'd0) && (v_nxt == 11'd0);

            if (!checking || hs_lead) begin
                to_cnt <= 12'd0;
            end else if (to_cnt != 12'hFFF) begin
                to_cnt <= to_cnt + 12'd1;
            end

            // A frame is clean when no error landed between two VS leading edges;
            // an error coinciding with the VS edge belongs to the frame it closes.
            if (checking) begin
                if (vs_lead) begin
                    clean_cnt <= (err_c || dirty) ? 4'd0 : clean_cnt + 4'd1;
                    dirty     <= 1'b0;
                end else if (err_c) begin
                    clean_cnt <= 4'd0;
                    dirty     <= 1'b1;
                end
            end

            case (state)
                SEARCH: begin
                    if (vs_lead) begin
                        state     <= VERIFY;
                        clean_cnt <= 4'd0;
                        dirty     <= 1'b0;
                    end
                end
                VERIFY: begin
                    if (timeout)      state <= SEARCH;
                    else if (promote) state <= LOCKED;
                end
                LOCKED: begin
                    if (timeout) begin
                        state <= SEARCH;
                    end else if (err_q) begin
                        state     <= VERIFY;
                        clean_cnt <= 4'd0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down timing (40x14 frame)
// driven by an in-bench sync generator with fault injection knobs.
module tb_vga_sync_receiver;

    localparam int HA = 16, HF = 4, HSW = 8, HT = 40;
    localparam int VA = 6,  VF = 2, VSW = 2, VT = 14;
    localparam int FRAME = HT * VT;

    logic        clk, rst, hs, vs;
    logic [10:0] hcount, vcount;
    logic        blank, frame_start, locked, line_err, frame_err;

    int checks = 0;
    int errors = 0;

    int gh, gv, d1h, d1v, d2h, d2v;
    bit gen_en, short_line, vs_rise;
    int hs_extra, jump_v;

    vga_sync_receiver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs),
        .hcount(hcount), .vcount(vcount), .blank(blank),
        .frame_start(frame_start), .locked(locked),
        .line_err(line_err), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance the generator one pixel at the falling edge.
    task automatic step();
        logic prev_vs;
        @(negedge clk);
        d2h = d1h; d2v = d1v; d1h = gh; d1v = gv;
        if (gh >= (short_line ? HT - 2 : HT - 1)) begin
            gh = 0;
            short_line = 1'b0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh++;
        end
        if (jump_v >= 0 && gh == HA + HF) begin
            gv = jump_v;
            jump_v = -1;
        end
        prev_vs = vs;
        hs = !(gen_en && gh >= HA + HF && gh < HA + HF + HSW + hs_extra);
        vs = !(gen_en && gv >= VA + VF && gv < VA + VF + VSW);
        vs_rise = prev_vs && !vs;
    endtask

    task automatic wait_lock(output int nvs, output bit ok, output int nerr);
        nvs = 0; ok = 1'b0; nerr = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            step();
            if (vs_rise) nvs++;
            if (line_err || frame_err) nerr++;
            if (locked) ok = 1'b1;
        end
    endtask

    task automatic wait_gen(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step();
            if (gh == h && gv == v) ok = 1'b1;
        end
    endtask

    initial begin
        int nvs, nerr, fs_cnt, fs_first, fs_second, le_cnt, fall_at;
        bit ok;

        gh = 0; gv = 0; d1h = 0; d1v = 0; d2h = 0; d2v = 0;
        gen_en = 1'b1; short_line = 1'b0; hs_extra = 0; jump_v = -1; vs_rise = 1'b0;
        hs = 1'b1; vs = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_hcount", 32'(hcount), 0);
        chk("rst_vcount", 32'(vcount), 0);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_line_err", 32'(line_err), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        rst = 1'b0;

        // Initial acquisition: align on the first VS edge, lock after two clean frames.
        wait_lock(nvs, ok, nerr);
        chk("lock1_seen", 32'(ok), 1);
        chk("lock1_vs_edges", nvs, 3);
        chk("lock1_no_err", nerr, 0);

        // Tracking: counters follow the generator with a fixed delay.
        fs_cnt = 0; fs_first = -1; fs_second = -1; nerr = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i > 0) step();
            chk("track_hcount", 32'(hcount), d2h);
            chk("track_vcount", 32'(vcount), d2v);
            chk("track_blank", 32'(blank), (d2h >= HA || d2v >= VA) ? 1 : 0);
            chk("track_frame_start", 32'(frame_start), (d2h == 0 && d2v == 0) ? 1 : 0);
            if (line_err || frame_err) nerr++;
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
            end
        end
        chk("track_no_err", nerr, 0);
        chk("frame_start_count", fs_cnt, 2);
        chk("frame_start_period", fs_second - fs_first, FRAME);
        chk("track_locked", 32'(locked), 1);

        // One HS pulse widened by a pixel.
        wait_gen(0, 2, ok);
        chk("widen_reach", 32'(ok), 1);
        hs_extra = 1; le_cnt = 0;
        for (int i = 0; i < HT + 4; i++) begin
            step();
            if (line_err) le_cnt++;
        end
        hs_extra = 0;
`ifdef SYNC_WIDTH_CHECK_EN
        chk("widen_line_err", le_cnt, 1);
        wait_lock(nvs, ok, nerr);
        chk("widen_relock", 32'(ok), 1);
`else
        chk("widen_line_err", le_cnt, 0);
        chk("widen_locked", 32'(locked), 1);
`endif

        // One line shortened to HT-1 pixels.
        wait_gen(0, 2, ok);
        chk("short_reach", 32'(ok), 1);
        short_line = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            chk("short_frame_err", 32'(frame_err), 0);
            if (line_err) ok = 1'b1;
        end
        chk("short_line_err_seen", 32'(ok), 1);
        chk("short_locked_at_pulse", 32'(locked), 1);
        step();
        chk("short_line_err_single", 32'(line_err), 0);
        chk("short_locked_dropped", 32'(locked), 0);
        wait_lock(nvs, ok, nerr);
        chk("short_relock", 32'(ok), 1);
        chk("short_relock_vs_edges", nvs, 3);
        chk("short_relock_no_err", nerr, 0);

        // Sync lost while locked.
        wait_gen(0, 1, ok);
        gen_en = 1'b0; nerr = 0; fall_at = -1;
        for (int i = 1; i <= 200 && fall_at < 0; i++) begin
            step();
            if (line_err || frame_err) nerr++;
            if (i == 40) chk("timeout_still_locked", 32'(locked), 1);
            if (!locked) fall_at = i;
        end
        chk("timeout_fell", 32'(fall_at > 40), 1);
        chk("timeout_hcount", 32'(hcount), 0);
        chk("timeout_vcount", 32'(vcount), 0);
        chk("timeout_blank", 32'(blank), 1);
        repeat (10) begin
            step();
            if (line_err || frame_err) nerr++;
        end
        chk("timeout_hold_hcount", 32'(hcount), 0);
        chk("timeout_hold_locked", 32'(locked), 0);
        chk("timeout_no_err", nerr, 0);

        wait_gen(HT - 1, VT - 1, ok);
        gen_en = 1'b1;
        wait_lock(nvs, ok, nerr);
        chk("relock_after_timeout", 32'(ok), 1);

        // Asynchronous reset in the middle of a line.
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            step();
            if (hcount == 11'd30 && vcount == 11'd3) ok = 1'b1;
        end
        chk("midrst_reach", 32'(ok), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_hcount", 32'(hcount), 0);
        chk("midrst_vcount", 32'(vcount), 0);
        chk("midrst_blank", 32'(blank), 1);
        chk("midrst_locked", 32'(locked), 0);
        repeat (3) step();
        rst = 1'b0;
        wait_lock(nvs, ok, nerr);
        chk("midrst_relock", 32'(ok), 1);
        chk("midrst_vs_edges", nvs, 3);

        // HS and VS leading edges together, only the line number is wrong.
        wait_gen(0, 3, ok);
        chk("simul_reach", 32'(ok), 1);
        jump_v = VA + VF;
        repeat (HA + HF) step();
        repeat (2) step();
        chk("simul_frame_err", 32'(frame_err), 1);
        chk("simul_line_err", 32'(line_err), 0);
        chk("simul_hcount", 32'(hcount), HA + HF);
        chk("simul_vcount", 32'(vcount), VA + VF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
